// File: rtl/dec_pkg.sv
// Shared definitions for the pipelined opcode decoder: class codes, FSM states
// and the decode-record flag bundle.
package dec_pkg;

    localparam logic [1:0] CLS_IMME = 2'b00;
    localparam logic [1:0] CLS_CAL  = 2'b01;
    localparam logic [1:0] CLS_COPY = 2'b10;
    localparam logic [1:0] CLS_COND = 2'b11;

    typedef enum logic {
        S_OP,
        S_EXT
    } state_t;

    typedef struct packed {
        logic imme;
        logic cal;
        logic copy;
        logic cond;
        logic ext;
    } dec_rec_t;

    function automatic dec_rec_t class_flags(input logic [1:0] cls);
        dec_rec_t r;
        r      = '0;
        r.imme = (cls == CLS_IMME);
        r.cal  = (cls == CLS_CAL);
        r.copy = (cls == CLS_COPY);
        r.cond = (cls == CLS_COND);
        return r;
    endfunction

endpackage

// File: rtl/dec_fields.sv
// Combinational field extraction for one instruction word: class flags,
// operand fields, short immediate and detection of the long immediate form.
module dec_fields
    import dec_pkg::*;
#(
    parameter int OPW     = 8,
    parameter int REGW    = 3,
    parameter int EXT_IMM = 1
) (
    input  logic [OPW-1:0]  word,
    output dec_rec_t        rec,
    output logic [OPW-1:0]  imm,
    output logic [OPW-3:0]  field,
    output logic [REGW-1:0] src,
    output logic [REGW-1:0] dst,
    output logic            is_long
);

    logic [1:0] cls;

    assign cls   = word[OPW-1:OPW-2];
    assign rec   = class_flags(cls);
    assign field = word[OPW-3:0];
    assign src   = word[2*REGW-1:REGW];
    assign dst   = word[REGW-1:0];

    // With the extended form enabled, bit OPW-3 selects long form and is not
    // part of the short immediate.
    generate
        if (EXT_IMM != 0) begin : g_ext
            assign imm     = {3'b000, word[OPW-4:0]};
            assign is_long = (cls == CLS_IMME) && word[OPW-3];
        end else begin : g_no_ext
            assign imm     = {2'b00, word[OPW-3:0]};
            assign is_long = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/dec_pipe.sv
// Registered opcode decoder on a valid/ready stream, with a two-word
// extended-immediate form and a wrapping sequence tag on each record.
module dec_pipe
    import dec_pkg::*;
#(
    parameter int OPW     = 8,
    parameter int REGW    = 3,
    parameter int EXT_IMM = 1,
    parameter int SEQW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_imme,
    output logic            out_cal,
    output logic            out_copy,
    output logic            out_cond,
    output logic            out_ext,
    output logic [OPW-1:0]  out_imm,
    output logic [OPW-3:0]  out_field,
    output logic [REGW-1:0] out_src,
    output logic [REGW-1:0] out_dst,
    output logic [SEQW-1:0] out_seq
);

    state_t          state_q, state_d;
    logic [OPW-3:0]  lat_field_q, lat_field_d;
    logic [REGW-1:0] lat_src_q, lat_src_d;
    logic [REGW-1:0] lat_dst_q, lat_dst_d;

    logic            valid_q, valid_d;
    dec_rec_t        rec_q, rec_d;
    logic [OPW-1:0]  imm_q, imm_d;
    logic [OPW-3:0]  field_q, field_d;
    logic [REGW-1:0] src_q, src_d;
    logic [REGW-1:0] dst_q, dst_d;
    logic [SEQW-1:0] seq_q, seq_d;

    dec_rec_t        f_rec;
    logic [OPW-1:0]  f_imm;
    logic [OPW-3:0]  f_field;
    logic [REGW-1:0] f_src, f_dst;
    logic            f_long;
    logic            accept;

    dec_fields #(
        .OPW     (OPW),
        .REGW    (REGW),
        .EXT_IMM (EXT_IMM)
    ) u_fields (
        .word    (in_data),
        .rec     (f_rec),
        .imm     (f_imm),
        .field   (f_field),
        .src     (f_src),
        .dst     (f_dst),
        .is_long (f_long)
    );

    assign in_ready = rst && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        lat_field_d = lat_field_q;
        lat_src_d   = lat_src_q;
        lat_dst_d   = lat_dst_q;
        valid_d     = valid_q;
        rec_d       = rec_q;
        imm_d       = imm_q;
        field_d     = field_q;
        src_d       = src_q;
        dst_d       = dst_q;
        seq_d       = seq_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            seq_d   = seq_q + SEQW'(1);
        end

        if (accept) begin
            if (state_q == S_EXT) begin
                // Extension word is the immediate verbatim; fields come from the opcode.
                state_d   = S_OP;
                valid_d   = 1'b1;
                rec_d     = '0;
                rec_d.imme = 1'b1;
                rec_d.ext  = 1'b1;
                imm_d     = in_data;
                field_d   = lat_field_q;
                src_d     = lat_src_q;
                dst_d     = lat_dst_q;
            end else if (f_long) begin
                state_d     = S_EXT;
                lat_field_d = f_field;
                lat_src_d   = f_src;
                lat_dst_d   = f_dst;
            end else begin
                valid_d = 1'b1;
                rec_d   = f_rec;
                imm_d   = f_imm;
                field_d = f_field;
                src_d   = f_src;
                dst_d   = f_dst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_OP;
            lat_field_q <= '0;
            lat_src_q   <= '0;
            lat_dst_q   <= '0;
            valid_q     <= 1'b0;
            rec_q       <= '0;
            imm_q       <= '0;
            field_q     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            lat_field_q <= lat_field_d;
            lat_src_q   <= lat_src_d;
            lat_dst_q   <= lat_dst_d;
            valid_q     <= valid_d;
            rec_q       <= rec_d;
            imm_q       <= imm_d;
            field_q     <= field_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            seq_q       <= seq_d;
        end
    end

    assign out_valid = valid_q;
    assign out_imme  = rec_q.imme;
    assign out_cal   = rec_q.cal;
    assign out_copy  = rec_q.copy;
    assign out_cond  = rec_q.cond;
    assign out_ext   = rec_q.ext;
    assign out_imm   = imm_q;
    assign out_field = field_q;
    assign out_src   = src_q;
    assign out_dst   = dst_q;
    assign out_seq   = seq_q;

endmodule
